// File: rtl/neural_layer_sequencer.sv
// ---------------------------------------------------------------------------
// neural_layer_sequencer
//
// Purpose:
//   Runs one load/evaluate sequence on a neural unit bank:
//     1. Streams four 8-bit weights into bank addresses 0..3.
//     2. Waits SETTLE_CYCLES idle cycles.
//     3. Pulses sumTrigger.
//     4. Waits for a rising edge of layerDone, then captures layerOut.
//   If no edge arrives within TIMEOUT_CYCLES, the sequence is abandoned
//   and a sticky timeout flag is raised.
//
// Parameters:
//   SETTLE_CYCLES  (1..15)  idle cycles between the last write and sumTrigger
//   TIMEOUT_CYCLES (1..255) maximum wait for a layerDone rising edge
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, mode_sel     sequence request and layer select (sampled in IDLE)
//   w_data, w_valid     weight stream in
//   w_ready             weight stream ready (high only while loading)
//   weight, address     bank write data and address (hold value between writes)
//   write               one-cycle bank write strobe
//   sumTrigger          one-cycle summation trigger
//   layer_Sel           layer select captured at start
//   layerOut, layerDone unit result and its valid
//   result              last captured layerOut
//   result_valid        one-cycle pulse when a new result is available
//   busy                high whenever the sequencer is not idle
//   timeout_err         sticky; cleared by the next accepted start
// ---------------------------------------------------------------------------
module neural_layer_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode_sel,
    input  logic [7:0]  w_data,
    input  logic        w_valid,
    output logic        w_ready,
    output logic [7:0]  weight,
    output logic [1:0]  address,
    output logic        write,
    output logic        sumTrigger,
    output logic        layer_Sel,
    input  logic [31:0] layerOut,
    input  logic        layerDone,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_TRIGGER = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  state_q,   state_d;
    logic [1:0]  wcnt_q,    wcnt_d;
    logic [3:0]  scnt_q,    scnt_d;
    logic [7:0]  tcnt_q,    tcnt_d;
    logic [7:0]  weight_q,  weight_d;
    logic [1:0]  address_q, address_d;
    logic        write_q,   write_d;
    logic        lsel_q,    lsel_d;
    logic [31:0] result_q,  result_d;
    logic        rvalid_q,  rvalid_d;
    logic        terr_q,    terr_d;
    logic        done_prev_q;
    logic        done_edge;

    // Only a fresh 0->1 transition completes WAIT_DONE; a level left high
    // from an earlier evaluation never does.
    assign done_edge = layerDone & ~done_prev_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        scnt_d    = scnt_q;
        tcnt_d    = tcnt_q;
        weight_d  = weight_q;
        address_d = address_q;
        write_d   = 1'b0;
        lsel_d    = lsel_q;
        result_d  = result_q;
        rvalid_d  = 1'b0;
        terr_d    = terr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    lsel_d  = mode_sel;
                    terr_d  = 1'b0;
                    wcnt_d  = 2'd0;
                end
            end
            S_LOAD: begin
                if (w_valid) begin
                    weight_d  = w_data;
                    address_d = wcnt_q;
                    write_d   = 1'b1;
                    wcnt_d    = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) begin
                        state_d = S_SETTLE;
                        scnt_d  = 4'd0;
                    end
                end
            end
            S_SETTLE: begin
                // The first SETTLE cycle carries the final write pulse, so the
                // count runs to SETTLE_CYCLES to give that many idle cycles.
                if (scnt_q == 4'(SETTLE_CYCLES)) begin
                    state_d = S_TRIGGER;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            S_TRIGGER: begin
                state_d = S_WAIT;
                tcnt_d  = 8'd0;
            end
            S_WAIT: begin
                // Edge is tested first so it wins over a coincident timeout.
                if (done_edge) begin
                    result_d = layerOut;
                    state_d  = S_DONE;
                end else if (tcnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_DONE: begin
                rvalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 2'd0;
            scnt_q      <= 4'd0;
            tcnt_q      <= 8'd0;
            weight_q    <= 8'd0;
            address_q   <= 2'd0;
            write_q     <= 1'b0;
            lsel_q      <= 1'b0;
            result_q    <= 32'd0;
            rvalid_q    <= 1'b0;
            terr_q      <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            scnt_q      <= scnt_d;
            tcnt_q      <= tcnt_d;
            weight_q    <= weight_d;
            address_q   <= address_d;
            write_q     <= write_d;
            lsel_q      <= lsel_d;
            result_q    <= result_d;
            rvalid_q    <= rvalid_d;
            terr_q      <= terr_d;
            done_prev_q <= layerDone;
        end
    end

    assign w_ready      = (state_q == S_LOAD);
    assign sumTrigger   = (state_q == S_TRIGGER);
    assign busy         = (state_q != S_IDLE);
    assign weight       = weight_q;
    assign address      = address_q;
    assign write        = write_q;
    assign layer_Sel    = lsel_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_neural_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neural_layer_sequencer
//
// Purpose:
//   Drives directed and randomized load/evaluate sequences into
//   neural_layer_sequencer. Expected write order, latencies, results and
//   the timeout behaviour come from the sequencing rules.
//
// Ports:
//   None (top-level bench). The DUT is built with TIMEOUT_CYCLES = 10.
// ---------------------------------------------------------------------------
module tb_neural_layer_sequencer;

    localparam int SETTLE = 2;
    localparam int TMO    = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode_sel = 1'b0;
    logic [7:0]  w_data = 8'd0;
    logic        w_valid = 1'b0;
    logic [31:0] layerOut = 32'd0;
    logic        layerDone = 1'b0;
    logic        w_ready;
    logic [7:0]  weight;
    logic [1:0]  address;
    logic        write;
    logic        sumTrigger;
    logic        layer_Sel;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Event log filled by the monitor, one entry per observed pulse
    int          wr_addr_q[$];
    int          wr_data_q[$];
    int          wr_cyc_q[$];
    int          trig_q[$];
    int          rv_cyc_q[$];
    logic [31:0] rv_val_q[$];

    neural_layer_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode_sel    (mode_sel),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .weight      (weight),
        .address     (address),
        .write       (write),
        .sumTrigger  (sumTrigger),
        .layer_Sel   (layer_Sel),
        .layerOut    (layerOut),
        .layerDone   (layerDone),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (write) begin
                wr_addr_q.push_back(int'(address));
                wr_data_q.push_back(int'(weight));
                wr_cyc_q.push_back(cyc);
            end
            if (sumTrigger) trig_q.push_back(cyc);
            if (result_valid) begin
                rv_cyc_q.push_back(cyc);
                rv_val_q.push_back(result);
            end
            if (write || sumTrigger) check_eq("wr_trig_excl", 32'(write & sumTrigger), 32'd0);
        end
    end

    task automatic clear_log();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        trig_q.delete(); rv_cyc_q.delete(); rv_val_q.delete();
    endtask

    task automatic run_txn(input logic [3:0][7:0] w, input bit mode, input int gap_len,
                           input int dly, input bit stale, input bit expect_tmo,
                           input bit poke_start, input logic [31:0] lout);
        int idx, gap_left, budget, s_cyc, t_cyc, e_cyc;
        int exp_wr_cyc[4];
        bit acc, seen;
        logic [31:0] prev_result;
        clear_log();
        for (int i = 0; i < 4; i++) exp_wr_cyc[i] = 0;
        t_cyc = 0; e_cyc = 0;
        @(posedge clk); #1;
        prev_result = result;
        start = 1'b1; mode_sel = mode; w_valid = 1'b1; w_data = w[0]; s_cyc = cyc;
        if (stale) begin layerDone = 1'b1; layerOut = 32'h0BAD_0BAD; end
        idx = 0; gap_left = gap_len; budget = 0;
        while (idx < 4 && budget < 200) begin
            @(negedge clk); acc = w_valid && w_ready;
            @(posedge clk); #1;
            start = 1'b0; mode_sel = ~mode; budget++;
            if (budget == 1) begin
                check_eq("start_clr_err", 32'(timeout_err), 32'd0);
                check_eq("busy_load", 32'(busy), 32'd1);
                check_eq("w_ready_load", 32'(w_ready), 32'd1);
            end
            if (acc) begin exp_wr_cyc[idx] = cyc; idx++; end
            if (idx < 4) begin
                if (idx == 2 && gap_left > 0) begin w_valid = 1'b0; gap_left--; end
                else begin w_valid = 1'b1; w_data = w[idx]; end
            end else begin
                w_valid = 1'b0;
            end
        end
        check_eq("load_complete", idx, 4);

        seen = 1'b0; budget = 0;
        while (!seen && budget < 50) begin
            @(negedge clk);
            if (sumTrigger) begin seen = 1'b1; t_cyc = cyc; end
            budget++;
        end
        check_eq("trig_seen", 32'(seen), 32'd1);

        if (seen && !expect_tmo) begin
            if (stale) begin @(posedge clk); #1; layerDone = 1'b0; start = poke_start; end
            for (int k = 0; k < dly; k++) begin @(posedge clk); #1; start = poke_start; end
            layerDone = 1'b1; layerOut = lout; e_cyc = cyc;
            @(posedge clk); #1;
            start = poke_start; layerOut = ~lout;
            check_eq("busy_in_done", 32'(busy), 32'd1);
            @(posedge clk); #1;
            start = 1'b0;
            check_eq("busy_after_done", 32'(busy), 32'd0);
            check_eq("rv_level", 32'(result_valid), 32'd1);
            check_eq("result_val", result, lout);
        end else if (seen) begin
            for (int k = 0; k < TMO; k++) begin @(posedge clk); #1; end
            check_eq("tmo_not_early", 32'(timeout_err), 32'd0);
            check_eq("busy_waiting", 32'(busy), 32'd1);
            @(posedge clk); #1;
            check_eq("tmo_flag", 32'(timeout_err), 32'd1);
            check_eq("tmo_idle", 32'(busy), 32'd0);
            check_eq("tmo_result_kept", result, prev_result);
        end
        layerDone = 1'b0;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end

        check_eq("n_writes", wr_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check_eq("wr_addr", wr_addr_q[i], i);
            check_eq("wr_data", wr_data_q[i], 32'(w[i]));
            check_eq("wr_cycle", wr_cyc_q[i], exp_wr_cyc[i]);
        end
        if (gap_len == 0 && wr_cyc_q.size() > 0) check_eq("first_wr_lat", wr_cyc_q[0], s_cyc + 2);
        check_eq("n_trig", trig_q.size(), 1);
        if (wr_cyc_q.size() == 4 && seen) check_eq("trig_lat", t_cyc, wr_cyc_q[3] + SETTLE + 1);
        check_eq("n_rv", rv_cyc_q.size(), expect_tmo ? 0 : 1);
        if (!expect_tmo && rv_cyc_q.size() == 1) begin
            check_eq("rv_lat", rv_cyc_q[0], e_cyc + 2);
            check_eq("rv_result", rv_val_q[0], lout);
        end
        check_eq("layer_sel", 32'(layer_Sel), 32'(mode));
        check_eq("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_load();
        clear_log();
        @(posedge clk); #1;
        start = 1'b1; mode_sel = 1'b1; w_valid = 1'b1; w_data = 8'hA1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; w_data = 8'hA2;
        @(posedge clk); #1; w_data = 8'hA3;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_weight", 32'(weight), 32'd0);
        check_eq("rst_address", 32'(address), 32'd0);
        check_eq("rst_write", 32'(write), 32'd0);
        check_eq("rst_trig", 32'(sumTrigger), 32'd0);
        check_eq("rst_lsel", 32'(layer_Sel), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_rv", 32'(result_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wready", 32'(w_ready), 32'd0);
        check_eq("rst_terr", 32'(timeout_err), 32'd0);
        w_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_write_hold", 32'(write), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_release_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0][7:0] w;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("init_busy", 32'(busy), 32'd0);
        check_eq("init_wready", 32'(w_ready), 32'd0);
        check_eq("init_write", 32'(write), 32'd0);
        check_eq("init_trig", 32'(sumTrigger), 32'd0);
        check_eq("init_result", result, 32'd0);
        check_eq("init_rv", 32'(result_valid), 32'd0);
        check_eq("init_terr", 32'(timeout_err), 32'd0);
        check_eq("init_weight", 32'(weight), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal sequence
        run_txn({8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
        // Stalled stream between 2nd and 3rd weight
        w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_txn(w, 1'b1, 5, 2, 1'b0, 1'b0, 1'b0, $urandom);
        // Timeout, then a fresh start that must clear the flag
        w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_txn(w, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 32'h0);
        w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_txn(w, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, $urandom);
        // Stale layerDone level
        w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_txn(w, 1'b0, 0, 2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        // start held during WAIT_DONE and DONE
        w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_txn(w, 1'b1, 0, 4, 1'b0, 1'b0, 1'b1, $urandom);
        // Reset mid-LOAD, then a fresh sequence from address 0
        reset_mid_load();
        run_txn({8'h04, 8'h03, 8'h02, 8'h01}, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001);

        for (int n = 0; n < 10; n++) begin
            w = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            run_txn(w, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                    1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/neural_layer_sequencer.md
NEURAL_LAYER_SEQUENCER -- requirements
Module: neural_layer_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles between the last weight write and the sumTrigger pulse (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for layerDone after sumTrigger (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request one load/evaluate sequence.
REQ-006 SHALL have port mode_sel, input, 1, layer select, captured at accepted start.
REQ-007 SHALL have port w_data, input, 8, weight stream data.
REQ-008 SHALL have port w_valid, input, 1, w_data valid.
REQ-009 SHALL have port w_ready, output, 1, sequencer accepts w_data this cycle.
REQ-010 SHALL have port weight, output, 8, weight value driven to the neural unit bank.
REQ-011 SHALL have port address, output, 2, bank address.
REQ-012 SHALL have port write, output, 1, bank write strobe.
REQ-013 SHALL have port sumTrigger, output, 1, single-cycle summation trigger.
REQ-014 SHALL have port layer_Sel, output, 1, registered copy of mode_sel.
REQ-015 SHALL have port layerOut, input, 32, unit result.
REQ-016 SHALL have port layerDone, input, 1, unit result valid.
REQ-017 SHALL have port result, output, 32, captured layerOut.
REQ-018 SHALL have port result_valid, output, 1, one-cycle pulse when result updates.
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-020 SHALL have port timeout_err, output, 1, sticky error flag, cleared by the next accepted start.

Function
REQ-021 SHALL implement states IDLE, LOAD, SETTLE, TRIGGER, WAIT_DONE, DONE.
REQ-022 IDLE: start=1 SHALL move to LOAD next cycle, capture mode_sel into layer_Sel, clear timeout_err, and zero the weight counter.
REQ-023 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-024 w_ready SHALL be 1 only in LOAD, and combinational from state.
REQ-025 Each cycle with w_valid&w_ready SHALL, on the next cycle, set weight=w_data, address=counter and write=1 for exactly one cycle, then increment the 2-bit counter.
REQ-026 Weights SHALL be written in address order 0,1,2,3; gaps in w_valid SHALL stall LOAD indefinitely.
REQ-027 Acceptance of the 4th weight (counter=3) SHALL move to SETTLE; the counter SHALL then wrap to 0.
REQ-028 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted from the cycle after the final write pulse.
REQ-029 TRIGGER SHALL last one cycle with sumTrigger=1, then go to WAIT_DONE.
REQ-030 WAIT_DONE SHALL react only to a rising edge of layerDone (registered previous value 0, current 1); a level already high on entry SHALL NOT complete.
REQ-031 On a layerDone rising edge, WAIT_DONE SHALL capture layerOut into result and go to DONE.
REQ-032 WAIT_DONE SHALL count cycles; at TIMEOUT_CYCLES without an edge, it SHALL set timeout_err=1, leave result unchanged, and return to IDLE with no result_valid.
REQ-033 If a rising edge occurs in the same cycle the timeout count is reached, the edge SHALL win.
REQ-034 DONE SHALL assert result_valid for one cycle, then return to IDLE.
REQ-035 Latency SHALL be: start to first write = 2 cycles with w_valid held 1; last write to sumTrigger = SETTLE_CYCLES+1 cycles; layerDone edge to result_valid = 2 cycles.
REQ-036 write and sumTrigger SHALL never be high in the same cycle.
REQ-037 weight and address SHALL hold their last values when write=0.

Reset
REQ-038 rst_n=0 at a clock edge SHALL force IDLE, and set weight=0, address=0, write=0, sumTrigger=0, layer_Sel=0, result=0, result_valid=0, timeout_err=0, and clear all counters and the edge register.
REQ-039 Reset asserted mid-sequence (any state) SHALL abort without a further write or sumTrigger pulse after the reset edge.
REQ-040 busy and w_ready SHALL be 0 during and immediately after reset.

Verification
REQ-041 Nominal: start, weights 0x11,0x22,0x33,0x44 back-to-back, layerDone rises 3 cycles after sumTrigger with layerOut=0x0000_1234 -> writes at addresses 0..3 in consecutive cycles, sumTrigger 3 cycles after the last write, result=0x1234, one result_valid pulse.
REQ-042 Stalled stream: w_valid low 5 cycles between the 2nd and 3rd weight -> exactly 4 write pulses, addresses 0,1,2,3, no early SETTLE.
REQ-043 Timeout: TIMEOUT_CYCLES=10, layerDone held 0 -> timeout_err=1 exactly 10 cycles after WAIT_DONE entry, IDLE, no result_valid; the next start clears timeout_err.
REQ-044 Stale done: layerDone held 1 through TRIGGER, drops, then rises with layerOut=0xDEAD_BEEF -> completes only on the new rising edge with result=0xDEADBEEF.
REQ-045 Reset mid-LOAD after 2 weights -> all outputs at reset values next cycle; a fresh start writes from address 0.
REQ-046 start pulsed during WAIT_DONE and DONE -> ignored, single result_valid, and busy falls only after DONE.
